// File: rtl/pes_seq_serializer_if.sv
// Parallel-word handshake and serial output bundle for pes_seq_serializer.
interface pes_seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             sequence_out;
  logic             bit_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output data_in, data_valid,
    input  data_ready, sequence_out, bit_valid, busy, frame_done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, sequence_out, bit_valid, busy, frame_done
  );
endinterface

// File: rtl/pes_seq_serializer.sv
// Word-to-bit serializer with shifter plus one-word holding register.
// Optional even-parity trailer bit enabled by defining PES_SEQ_PARITY_EN.
module pes_seq_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  pes_seq_serializer_if.slave bus
);

`ifdef PES_SEQ_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int            CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic             seq_q, seq_n;
  logic             bv_q, bv_n;
  logic             fd_q, fd_n;
  logic             xfer, needs_word, load, head;
  logic [WIDTH-1:0] load_word;
`ifdef PES_SEQ_PARITY_EN
  logic             par, par_n;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      seq_q     <= IDLE_BIT;
      bv_q      <= 1'b0;
      fd_q      <= 1'b0;
`ifdef PES_SEQ_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      seq_q     <= seq_n;
      bv_q      <= bv_n;
      fd_q      <= fd_n;
`ifdef PES_SEQ_PARITY_EN
      par       <= par_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    hold_n      = hold;
    hold_full_n = hold_full;
    load        = 1'b0;
    load_word   = hold;
`ifdef PES_SEQ_PARITY_EN
    par_n       = par;
`endif
    xfer       = bus.data_valid && !hold_full;
    needs_word = (state == IDLE) || (cnt == LAST);

    if (needs_word) begin
      if (hold_full) begin
        load        = 1'b1;
        load_word   = hold;
        hold_full_n = 1'b0;
      end else if (xfer) begin
        // bypass: word goes straight into the shifter, hold stays empty
        load      = 1'b1;
        load_word = bus.data_in;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end else begin
      cnt_n = cnt + CW'(1);
      sh_n  = (MSB_FIRST != 0) ? (sh << 1) : (sh >> 1);
      if (xfer) begin
        hold_n      = bus.data_in;
        hold_full_n = 1'b1;
      end
    end

    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sh_n    = load_word;
`ifdef PES_SEQ_PARITY_EN
      par_n   = ^load_word;
`endif
    end

    // output bit is registered, so it is decoded from next-state values
    head  = (MSB_FIRST != 0) ? sh_n[WIDTH-1] : sh_n[0];
    seq_n = IDLE_BIT;
    if (state_n == SHIFT) begin
      seq_n = head;
`ifdef PES_SEQ_PARITY_EN
      if (cnt_n == CW'(WIDTH)) seq_n = par_n;
`endif
    end
    bv_n = (state_n == SHIFT);
    fd_n = (state_n == SHIFT) && (cnt_n == LAST);
  end

  assign bus.data_ready   = !hold_full;
  assign bus.busy         = (state == SHIFT) || hold_full;
  assign bus.sequence_out = seq_q;
  assign bus.bit_valid    = bv_q;
  assign bus.frame_done   = fd_q;

endmodule

// File: tb/tb_pes_seq_serializer.sv
// Scoreboard bench: MSB-first (idle 0) and LSB-first (idle 1) serializers on shared stimulus.
module tb_pes_seq_serializer;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pes_seq_serializer_if #(.WIDTH(W)) ifm ();
  pes_seq_serializer_if #(.WIDTH(W)) ifl ();

  pes_seq_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_m (
    .clock(clock), .reset(reset), .bus(ifm.slave));
  pes_seq_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut_l (
    .clock(clock), .reset(reset), .bus(ifl.slave));

  typedef struct packed {logic b; logic last;} sb_t;
  sb_t qm[$];
  sb_t ql[$];
  int  words = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    ifm.data_valid = v; ifl.data_valid = v;
    ifm.data_in    = d; ifl.data_in    = d;
  endtask

  // offers a word; junk is presented whenever ready is low to prove it is ignored
  task automatic send(input logic [W-1:0] w);
    logic rdy;
    int   n;
    n = 0;
    forever begin
      rdy = ifm.data_ready;
      drive(1'b1, rdy ? w : W'($urandom));
      @(posedge clock); #2;
      if (rdy) break;
      n++;
      if (n > 100) begin
        n_checks++; n_fail++;
        $error("FAIL send_timeout observed=%0d expected=%0d", n, 100);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  always @(negedge clock) begin
    sb_t em, el;
    if (mon_en) begin
      em = '{b: 1'b0, last: 1'b0};
      el = '{b: 1'b1, last: 1'b0};
      chk("m_ready", ifm.data_ready, words < 2);
      chk("l_ready", ifl.data_ready, words < 2);
      chk("m_busy", ifm.busy, qm.size() != 0);
      chk("l_busy", ifl.busy, ql.size() != 0);
      chk("m_valid", ifm.bit_valid, qm.size() != 0);
      chk("l_valid", ifl.bit_valid, ql.size() != 0);
      if (qm.size() != 0) em = qm.pop_front();
      if (ql.size() != 0) el = ql.pop_front();
      chk("m_bit", ifm.sequence_out, em.b);
      chk("l_bit", ifl.sequence_out, el.b);
      chk("m_done", ifm.frame_done, em.last);
      chk("l_done", ifl.frame_done, el.last);
      if (em.last) words--;
      if (reset) begin
        qm.delete(); ql.delete(); words = 0;
      end else if (ifm.data_valid && ifm.data_ready) begin
        for (int i = 0; i < W; i++) begin
`ifdef PES_SEQ_PARITY_EN
          qm.push_back('{b: ifm.data_in[W-1-i], last: 1'b0});
          ql.push_back('{b: ifm.data_in[i], last: 1'b0});
`else
          qm.push_back('{b: ifm.data_in[W-1-i], last: (i == W-1)});
          ql.push_back('{b: ifm.data_in[i], last: (i == W-1)});
`endif
        end
`ifdef PES_SEQ_PARITY_EN
        qm.push_back('{b: ^ifm.data_in, last: 1'b1});
        ql.push_back('{b: ^ifm.data_in, last: 1'b1});
`endif
        words++;
      end
    end
  end

  initial begin
    drive(1'b0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2 mon_en = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
    idle(5);

    // single word, then drain
    send(8'b0101_0110);
    idle(12);

    // back-to-back with valid held
    send(8'hA5);
    send(8'h3C);
    idle(20);

    // LSB-first single-bit check
    send(8'h01);
    idle(12);

    // continuous streaming, including junk during hold-full cycles
    for (int k = 0; k < 5; k++) send(W'($urandom));
    idle(50);

    // reset mid-word with hold occupied
    send(8'hFF);
    send(8'h00);
    idle(2);
    reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
    idle(15);

    // random words with random gaps
    for (int k = 0; k < 6; k++) begin
      send(W'($urandom));
      idle($urandom_range(0, 10));
    end
    idle(25);

    send(8'h07);
    idle(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pes_seq_serializer.md
Name: pes_seq_serializer

Overview:
- Upstream feeder for the sequence detector: accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `sequence_out`, which drives the detector's `sequence_in`.
- Has a two-deep buffer (shift register plus holding register), so consecutive words stream with no idle gap.
- Drives a known idle level when it has no data, so the downstream detector never sees X.

Parameters:
- WIDTH, 8, bits per word (>=2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 leaves first; 0 = bit 0 leaves first.
- IDLE_BIT, 0, level driven on `sequence_out` while no bit is valid.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  parallel word to serialize.
- data_valid  in  1  `data_in` is valid.
- data_ready  out  1  block can accept a word this cycle.
- sequence_out  out  1  registered serial bit to the detector.
- bit_valid  out  1  `sequence_out` carries a data bit this cycle.
- busy  out  1  shifter or holding register occupied.
- frame_done  out  1  one-cycle pulse coincident with the last bit of each word.

Behaviour:
- Interface:
  - One clock, `clock`.
  - `reset` is synchronous and active-high.
  - All outputs are registered except `data_ready` and `busy`, which are decoded from state registers.
- Reset values:
  - `sequence_out` = IDLE_BIT.
  - `bit_valid` = 0, `frame_done` = 0, `busy` = 0, `data_ready` = 1.
  - Shifter state = IDLE, holding register empty, bit counter = 0.
- Handshake:
  - A transfer occurs on a rising edge where `data_valid` && `data_ready`.
  - `data_ready` = !hold_full and does not depend on `data_valid`.
  - `data_in` is sampled only on a transfer.
- Shifter FSM states:
  - IDLE: `bit_valid` = 0, `sequence_out` = IDLE_BIT.
  - SHIFT: one bit per cycle; counter runs 0..WIDTH-1.
- Load rule, evaluated every edge. The shifter "needs a word" if it is in IDLE, or in SHIFT with counter = WIDTH-1 (last bit currently on the output).
  - Needs a word and hold full: load from hold, clear hold, stay/enter SHIFT.
  - Needs a word, hold empty and a transfer occurs: load `data_in` directly (bypass).
  - Needs a word and nothing is available: go to IDLE.
  - Not needing a word and a transfer occurs: write `data_in` into hold.
- Latency:
  - Word accepted at edge N while IDLE: its first bit appears on `sequence_out` after edge N (visible in cycle N+1).
  - Bits occupy WIDTH consecutive cycles.
  - A following word buffered in time starts on the very next cycle (zero gap).
- Bit order:
  - MSB_FIRST=1: bit WIDTH-1 down to bit 0.
  - MSB_FIRST=0: bit 0 up to bit WIDTH-1.
- Pulses and status:
  - `frame_done` = 1 exactly in the cycle the last bit of a word is on `sequence_out`; it is asserted once per word, back-to-back included.
  - `busy` = (state == SHIFT) || hold_full.
- Boundaries:
  - Hold full: `data_ready` = 0, and `data_in` is ignored regardless of `data_valid`.
  - Transfer in the same cycle the last bit shifts, with hold empty: bypass into the shifter; nothing goes into hold.
  - Reset asserted mid-word: the partial word and the hold contents are discarded; outputs take reset values on that edge. No partial bit stream resumes afterwards.
  - `data_valid` held high continuously: exactly one word is accepted per WIDTH cycles at steady state, after the initial two-word fill.

Optional Feature:
- Macro: PES_SEQ_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the word) is appended after the last data bit, giving a WIDTH+1-cycle frame.
  - `bit_valid` = 1 during the parity bit.
  - `frame_done` pulses on the parity bit instead of the last data bit.
  - The "needs a word" condition moves to the parity cycle.
- Undefined:
  - Frame is WIDTH cycles, with no parity logic or extra counter state.

Test Plan:
- Reset, then idle 5 cycles -> `sequence_out` = 0, `bit_valid` = 0, `data_ready` = 1, `busy` = 0 every cycle.
- WIDTH=8, MSB_FIRST=1, accept 8'b0101_0110 at edge N -> cycles N+1..N+8 give `sequence_out` 0,1,0,1,0,1,1,0 with `bit_valid` = 1; `frame_done` = 1 only in cycle N+8; idle from cycle N+9.
- Back-to-back, `data_valid` held with 8'hA5 then 8'h3C -> 16 contiguous valid bits 10100101 00111100, no gap; `data_ready` = 0 while hold is full; two `frame_done` pulses, 8 cycles apart.
- MSB_FIRST=0, word 8'h01 -> bits 1,0,0,0,0,0,0,0.
- Reset asserted at bit 3 of 8'hFF with hold containing 8'h00 -> next cycle `bit_valid` = 0, `sequence_out` = IDLE_BIT, `data_ready` = 1; no residual bits after reset deasserts.
- PES_SEQ_PARITY_EN defined, word 8'h07 -> 9 valid bits 0000_0111 then parity 1; `frame_done` on the 9th bit.
